// File: rtl/deser_align_ctrl.sv
// rtl/deser_align_ctrl.sv - lane alignment, lock tracking and symbol forwarding after the byte deserializer
// Optional build macro: DESER_ALIGN_OS_FWD_EN (forward correct ordered-set bytes while LOCKED)
module deser_align_ctrl #(
   parameter int LOCK_COUNT   = 4,
   parameter int UNLOCK_ERRS  = 2,
   parameter int HUNT_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset_L,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic       in_DK,
   output logic       bit_slip,
   output logic       locked,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       out_DK,
   output logic [7:0] err_count
);

   localparam logic [7:0] K_COM = 8'hBC;
   localparam logic [7:0] K_SKP = 8'h1C;
   localparam logic [7:0] K_IDL = 8'h7C;
   localparam logic [7:0] K_FTS = 8'h3C;
   localparam logic [7:0] K_STP = 8'hFB;
   localparam logic [7:0] K_SDP = 8'h5C;
   localparam logic [7:0] K_END = 8'hFD;
   localparam logic [7:0] K_EDB = 8'hFE;

   localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
   localparam logic [3:0] UNLK_CNT = 4'(UNLOCK_ERRS);
   localparam logic [7:0] HUNT_TO  = 8'(HUNT_TIMEOUT);

`ifdef DESER_ALIGN_OS_FWD_EN
   localparam logic OS_FWD = 1'b1;
`else
   localparam logic OS_FWD = 1'b0;
`endif

   typedef enum logic [1:0] {ST_HUNT, ST_CHECK, ST_LOCKED} state_t;

   state_t     state_q, state_d;
   logic [1:0] os_pos_q, os_pos_d;
   logic [7:0] os_sym_q, os_sym_d;
   logic [3:0] good_q, good_d;
   logic [3:0] errs_q, errs_d;
   logic [7:0] timer_q, timer_d;
   logic [7:0] err_count_q, err_count_d;
   logic       bit_slip_q, bit_slip_d;
   logic       locked_q, locked_d;
   logic       out_valid_q, out_valid_d;
   logic [7:0] out_data_q, out_data_d;
   logic       out_dk_q, out_dk_d;

   logic is_com, is_os_sym, is_legal_k, os_match;
   logic err, fwd_data, fwd_os;

   // Symbol classification of the incoming byte
   assign is_com     = in_DK && (in_data == K_COM);
   assign is_os_sym  = in_DK && (in_data inside {K_SKP, K_IDL, K_FTS});
   assign is_legal_k = in_DK && (in_data inside {K_COM, K_SKP, K_IDL, K_FTS,
                                                 K_STP, K_SDP, K_END, K_EDB});
   // Expected byte at the current ordered-set position (pos 0 = COM, 1 = any OS symbol, 2..3 = repeat)
   assign os_match   = (os_pos_q == 2'd0) ? is_com :
                       (os_pos_q == 2'd1) ? is_os_sym :
                                            (in_DK && (in_data == os_sym_q));

   // Next-state computation: alignment FSM, counters and forwarding decision
   always_comb begin
      state_d     = state_q;
      os_pos_d    = os_pos_q;
      os_sym_d    = os_sym_q;
      good_d      = good_q;
      errs_d      = errs_q;
      timer_d     = timer_q;
      err_count_d = err_count_q;
      bit_slip_d  = 1'b0;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      out_dk_d    = out_dk_q;
      err         = 1'b0;
      fwd_data    = 1'b0;
      fwd_os      = 1'b0;
      if (in_valid) begin
         case (state_q)
            ST_HUNT: begin
               // COM takes priority over a timeout landing on the same byte
               if (is_com) begin
                  state_d  = ST_CHECK;
                  os_pos_d = 2'd1;
                  good_d   = 4'd0;
                  timer_d  = 8'd0;
               end else if (timer_q + 8'd1 == HUNT_TO) begin
                  bit_slip_d = 1'b1;
                  timer_d    = 8'd0;
               end else begin
                  timer_d = timer_q + 8'd1;
               end
            end
            ST_CHECK: begin
               if (os_match) begin
                  if (os_pos_q == 2'd1) os_sym_d = in_data;
                  if (os_pos_q == 2'd3) begin
                     os_pos_d = 2'd0;
                     good_d   = good_q + 4'd1;
                     if (good_q + 4'd1 == LOCK_CNT) begin
                        state_d = ST_LOCKED;
                        good_d  = 4'd0;
                        errs_d  = 4'd0;
                     end
                  end else begin
                     os_pos_d = os_pos_q + 2'd1;
                  end
               end else begin
                  state_d  = ST_HUNT;
                  os_pos_d = 2'd0;
                  good_d   = 4'd0;
                  timer_d  = 8'd0;
               end
            end
            ST_LOCKED: begin
               if ((os_pos_q != 2'd0) && os_match) begin
                  fwd_os = 1'b1;
                  if (os_pos_q == 2'd1) os_sym_d = in_data;
                  if (os_pos_q == 2'd3) begin
                     os_pos_d = 2'd0;
                     errs_d   = 4'd0;
                  end else begin
                     os_pos_d = os_pos_q + 2'd1;
                  end
               end else begin
                  // No OS open, or the open OS is abandoned: the byte is parsed afresh
                  err      = (os_pos_q != 2'd0) || (in_DK && !is_legal_k);
                  os_pos_d = 2'd0;
                  if (is_com) begin
                     os_pos_d = 2'd1;
                     fwd_os   = 1'b1;
                  end else if (!in_DK || is_legal_k) begin
                     fwd_data = 1'b1;
                  end
               end
               if (err) begin
                  errs_d = errs_q + 4'd1;
                  if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
                  // The byte that drops lock is swallowed
                  if (errs_q + 4'd1 == UNLK_CNT) begin
                     state_d  = ST_HUNT;
                     os_pos_d = 2'd0;
                     good_d   = 4'd0;
                     timer_d  = 8'd0;
                     fwd_data = 1'b0;
                     fwd_os   = 1'b0;
                  end
               end
               if (fwd_data || (OS_FWD && fwd_os)) begin
                  out_valid_d = 1'b1;
                  out_data_d  = in_data;
                  out_dk_d    = in_DK;
               end
            end
            default: begin
               state_d  = ST_HUNT;
               os_pos_d = 2'd0;
               good_d   = 4'd0;
               timer_d  = 8'd0;
            end
         endcase
      end
      locked_d = (state_d == ST_LOCKED);
   end

   // State and registered outputs, asynchronously cleared
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q     <= ST_HUNT;
         os_pos_q    <= 2'd0;
         os_sym_q    <= 8'd0;
         good_q      <= 4'd0;
         errs_q      <= 4'd0;
         timer_q     <= 8'd0;
         err_count_q <= 8'd0;
         bit_slip_q  <= 1'b0;
         locked_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'd0;
         out_dk_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         os_pos_q    <= os_pos_d;
         os_sym_q    <= os_sym_d;
         good_q      <= good_d;
         errs_q      <= errs_d;
         timer_q     <= timer_d;
         err_count_q <= err_count_d;
         bit_slip_q  <= bit_slip_d;
         locked_q    <= locked_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_dk_q    <= out_dk_d;
      end
   end

   assign bit_slip  = bit_slip_q;
   assign locked    = locked_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_DK    = out_dk_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_deser_align_ctrl.sv
// tb/tb_deser_align_ctrl.sv - vector-table and directed-sequence bench for deser_align_ctrl
module tb_deser_align_ctrl;

   logic       clk = 1'b0;
   logic       reset_L = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic       in_DK = 1'b0;
   logic       bit_slip, locked, out_valid, out_DK;
   logic [7:0] out_data, err_count;

   int n_checks = 0;
   int n_err = 0;

`ifdef DESER_ALIGN_OS_FWD_EN
   localparam logic FWD = 1'b1;
`else
   localparam logic FWD = 1'b0;
`endif

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       k;
      logic       slip;
      logic       lk;
      logic       ov;
      logic [7:0] od;
      logic       odk;
      logic [7:0] ec;
   } vec_t;

   vec_t tbl[$];

   deser_align_ctrl dut (
      .clk       (clk),
      .reset_L   (reset_L),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_DK     (in_DK),
      .bit_slip  (bit_slip),
      .locked    (locked),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_DK    (out_DK),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic v, input logic [7:0] d, input logic k);
      @(negedge clk);
      in_valid = v;
      in_data  = d;
      in_DK    = k;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic v, input logic [7:0] d, input logic k, input logic slip,
                      input logic lk, input logic ov, input logic [7:0] od, input logic odk,
                      input logic [7:0] ec);
      vec_t r;
      r.v = v; r.d = d; r.k = k; r.slip = slip; r.lk = lk;
      r.ov = ov; r.od = od; r.odk = odk; r.ec = ec;
      tbl.push_back(r);
   endtask

   task automatic send_os(input logic [7:0] s);
      step(1'b1, 8'hBC, 1'b1);
      for (int j = 0; j < 3; j++) step(1'b1, s, 1'b1);
   endtask

   initial begin
      // Idle hunt: slip after the 16th valid byte, invalid cycles ignored
      for (int i = 1; i <= 20; i++) begin
         if (i == 6 || i == 16) add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0);
         add(1'b1, 8'h00, 1'b0, (i == 16), 1'b0, 1'b0, 8'h00, 1'b0, 8'd0);
      end
      // Four good SKP sets: lock on the cycle after the 16th byte
      for (int n = 0; n < 4; n++) begin
         add(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0);
         for (int j = 0; j < 3; j++)
            add(1'b1, 8'h1C, 1'b1, 1'b0, (n == 3 && j == 2), 1'b0, 8'h00, 1'b0, 8'd0);
      end
      add(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 8'd0);
      add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0);
      add(1'b1, 8'hFB, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFB, 1'b1, 8'd0);
      add(1'b1, 8'hBC, 1'b0, 1'b0, 1'b1, 1'b1, 8'hBC, 1'b0, 8'd0);
      // Good OS while locked: stripped or forwarded depending on build
      add(1'b1, 8'hBC, 1'b1, 1'b0, 1'b1, FWD, 8'hBC, 1'b1, 8'd0);
      for (int j = 0; j < 3; j++) add(1'b1, 8'h1C, 1'b1, 1'b0, 1'b1, FWD, 8'h1C, 1'b1, 8'd0);
      // Illegal K then good OS: one error, lock kept
      add(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'd1);
      add(1'b1, 8'hBC, 1'b1, 1'b0, 1'b1, FWD, 8'hBC, 1'b1, 8'd1);
      for (int j = 0; j < 3; j++) add(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, FWD, 8'h3C, 1'b1, 8'd1);
      add(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 8'd1);
      // Two malformed sets: reparsed K bytes forwarded, second error drops lock
      add(1'b1, 8'hBC, 1'b1, 1'b0, 1'b1, FWD, 8'hBC, 1'b1, 8'd1);
      add(1'b1, 8'h7C, 1'b1, 1'b0, 1'b1, FWD, 8'h7C, 1'b1, 8'd1);
      add(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 8'd2);
      add(1'b1, 8'h7C, 1'b1, 1'b0, 1'b1, 1'b1, 8'h7C, 1'b1, 8'd2);
      add(1'b1, 8'hBC, 1'b1, 1'b0, 1'b1, FWD, 8'hBC, 1'b1, 8'd2);
      add(1'b1, 8'h7C, 1'b1, 1'b0, 1'b1, FWD, 8'h7C, 1'b1, 8'd2);
      add(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd3);
      add(1'b1, 8'h7C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd3);
      add(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd3);
      // Back in HUNT with timer cleared on exit: 2 bytes so far, 14 more to slip
      for (int i = 1; i <= 14; i++)
         add(1'b1, 8'h00, 1'b0, (i == 14), 1'b0, 1'b0, 8'h00, 1'b0, 8'd3);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_slip", 8'(bit_slip), 8'd0);
      chk("rst_locked", 8'(locked), 8'd0);
      chk("rst_ov", 8'(out_valid), 8'd0);
      chk("rst_od", out_data, 8'd0);
      chk("rst_odk", 8'(out_DK), 8'd0);
      chk("rst_ec", err_count, 8'd0);
      @(negedge clk);
      reset_L = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].k);
         chk($sformatf("row%0d slip", i), 8'(bit_slip), 8'(tbl[i].slip));
         chk($sformatf("row%0d locked", i), 8'(locked), 8'(tbl[i].lk));
         chk($sformatf("row%0d ov", i), 8'(out_valid), 8'(tbl[i].ov));
         chk($sformatf("row%0d ec", i), err_count, tbl[i].ec);
         if (tbl[i].ov) begin
            chk($sformatf("row%0d od", i), out_data, tbl[i].od);
            chk($sformatf("row%0d odk", i), 8'(out_DK), 8'(tbl[i].odk));
         end
      end

      // COM on the byte that would time out: no slip
      for (int i = 0; i < 15; i++) step(1'b1, 8'h00, 1'b0);
      step(1'b1, 8'hBC, 1'b1);
      chk("com_vs_timeout_slip", 8'(bit_slip), 8'd0);
      for (int j = 0; j < 3; j++) step(1'b1, 8'h1C, 1'b1);
      // Non-COM after an OS in CHECK returns to HUNT
      step(1'b1, 8'h00, 1'b0);
      chk("check_exit_locked", 8'(locked), 8'd0);
      for (int i = 0; i < 15; i++) step(1'b1, 8'h00, 1'b0);
      chk("check_exit_no_early_slip", 8'(bit_slip), 8'd0);
      step(1'b1, 8'h00, 1'b0);
      chk("check_exit_slip", 8'(bit_slip), 8'd1);

      // Mid-OS mismatch in CHECK: full LOCK_COUNT sets needed afterwards
      send_os(8'h1C);
      step(1'b1, 8'hBC, 1'b1);
      step(1'b1, 8'h1C, 1'b1);
      step(1'b1, 8'h7C, 1'b1);
      for (int n = 0; n < 3; n++) send_os(8'h7C);
      step(1'b1, 8'hBC, 1'b1);
      step(1'b1, 8'h7C, 1'b1);
      step(1'b1, 8'h7C, 1'b1);
      chk("relock_not_early", 8'(locked), 8'd0);
      step(1'b1, 8'h7C, 1'b1);
      chk("relock", 8'(locked), 8'd1);

      // err_count saturates at 255 while lock holds
      for (int n = 0; n < 260; n++) begin
         step(1'b1, 8'h55, 1'b1);
         send_os(8'h3C);
      end
      chk("ec_sat", err_count, 8'hFF);
      chk("ec_sat_locked", 8'(locked), 8'd1);

      // Asynchronous reset mid-OS while locked
      step(1'b1, 8'hA5, 1'b0);
      chk("pre_rst_ov", 8'(out_valid), 8'd1);
      chk("pre_rst_od", out_data, 8'hA5);
      step(1'b1, 8'hBC, 1'b1);
      #3;
      reset_L = 1'b0;
      #1;
      chk("arst_locked", 8'(locked), 8'd0);
      chk("arst_ov", 8'(out_valid), 8'd0);
      chk("arst_od", out_data, 8'd0);
      chk("arst_odk", 8'(out_DK), 8'd0);
      chk("arst_ec", err_count, 8'd0);
      chk("arst_slip", 8'(bit_slip), 8'd0);
      in_valid = 1'b0;
      @(negedge clk);
      reset_L = 1'b1;
      for (int i = 0; i < 15; i++) step(1'b1, 8'h00, 1'b0);
      chk("post_rst_no_slip", 8'(bit_slip), 8'd0);
      chk("post_rst_ov", 8'(out_valid), 8'd0);
      step(1'b1, 8'h00, 1'b0);
      chk("post_rst_slip", 8'(bit_slip), 8'd1);
      chk("post_rst_locked", 8'(locked), 8'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
